alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 valid_i  input  1  operation request present this cycle.
REQ-005 ALUCtrl_i  input  3  op code from ALU control stage: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL.
REQ-006 data1_i  input  WIDTH  operand A (multiplicand for MUL).
REQ-007 data2_i  input  WIDTH  operand B (multiplier for MUL).
REQ-008 ready_o  output  1  block can accept a request this cycle.
REQ-009 valid_o  output  1  one-cycle pulse; data_o/zero_o hold a new result.
REQ-010 data_o  output  WIDTH  registered result.
REQ-011 zero_o  output  1  registered, high when data_o equals 0.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and MUL; ready_o SHALL be high iff state is IDLE.
REQ-013 A request SHALL be accepted on a rising edge where valid_i and ready_o are both high; valid_i while ready_o is low SHALL be ignored and not queued.
REQ-014 AND/OR/ADD/SUB SHALL complete at the accepting edge: request in cycle n -> valid_o high and result on data_o in cycle n+1; state stays IDLE.
REQ-015 ADD/SUB results SHALL be modulo 2^WIDTH (A+B, A-B); carry/borrow discarded.
REQ-016 Unlisted ALUCtrl_i codes SHALL complete as single-cycle ops with data_o = 0, zero_o = 1, valid_o pulsed.
REQ-017 MUL acceptance SHALL latch A, B, clear accumulator and iteration counter, and enter MUL.
REQ-018 Each MUL-state edge SHALL add the shifted multiplicand to the accumulator if multiplier LSB is 1, shift multiplicand left 1, multiplier right 1, increment counter.
REQ-019 MUL SHALL finalize at the edge performing iteration WIDTH-1: data_o = low WIDTH bits of A*B, valid_o pulsed, state -> IDLE; request in cycle n -> valid_o in cycle n+1+WIDTH.
REQ-020 valid_o SHALL be high for exactly one cycle per accepted request and SHALL never assert spontaneously.
REQ-021 data_o and zero_o SHALL hold their last values until the next completing edge, including during MUL iterations.
REQ-022 In the cycle valid_o is high the block SHALL be in IDLE and SHALL accept a new request (back-to-back, no bubble).
REQ-023 Operand or ALUCtrl_i changes after acceptance SHALL not affect an in-flight MUL.

Reset
REQ-024 While rst_i is high: state = IDLE, ready_o = 1, valid_o = 0, data_o = 0, zero_o = 1, counter/accumulator/operand registers = 0.
REQ-025 Reset asserted mid-MUL SHALL abort the operation immediately with no valid_o pulse; first acceptance possible on the first rising edge after rst_i falls.

Configuration
REQ-026 Macro MUL_EARLY_TERM_EN: when defined, MUL SHALL also finalize at the edge where the post-shift multiplier equals 0; latency = 1 + (index of highest set bit of B) + 1 cycles, B = 0 -> valid_o in cycle n+2.
REQ-027 Without MUL_EARLY_TERM_EN, MUL latency SHALL be fixed at WIDTH+1 cycles regardless of operands; results SHALL be identical in both builds.

Verification
REQ-028 ADD 0xFFFFFFFF + 0x00000001 in cycle n -> cycle n+1: valid_o=1, data_o=0, zero_o=1.
REQ-029 SUB 5 - 7, then AND 0xF0F0 & 0x0FF0 back-to-back -> 0xFFFFFFFE (zero_o=0) at n+1, 0x00F0 at n+2.
REQ-030 MUL 0x00010001 * 0x00010001 -> data_o=0x00020001, valid_o at n+33 (no macro); ready_o low n+1..n+32; valid_i pulses during MUL ignored.
REQ-031 With MUL_EARLY_TERM_EN: MUL 7*5 -> 35 at n+4; MUL 9*0 -> 0, zero_o=1 at n+2.
REQ-032 Assert rst_i at cycle n+10 of a MUL -> no valid_o, data_o=0, ready_o=1; new ADD 2+3 after release -> 5 next cycle.
REQ-033 ALUCtrl_i=3'b101, operands 3 and 4 -> data_o=0, zero_o=1, valid_o one cycle.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle AND/OR/ADD/SUB, iterative shift-add MUL.
// Optional macro MUL_EARLY_TERM_EN ends MUL once the remaining multiplier bits are all zero.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b011;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] mplier_shr;
    logic             mul_done;

    always_comb begin
        alu_res = '0;
        unique case (ALUCtrl_i)
            OP_AND:  alu_res = data1_i & data2_i;
            OP_OR:   alu_res = data1_i | data2_i;
            OP_ADD:  alu_res = data1_i + data2_i;
            OP_SUB:  alu_res = data1_i - data2_i;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step; the finalizing edge publishes acc_sum directly.
    always_comb begin
        acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shr = mplier_q >> 1;
`ifdef MUL_EARLY_TERM_EN
        mul_done   = (cnt_q == CNT_LAST) || (mplier_shr == '0);
`else
        mul_done   = (cnt_q == CNT_LAST);
`endif
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (ALUCtrl_i == OP_MUL) begin
                        mcand_d  = data1_i;
                        mplier_d = data2_i;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else begin
                        data_d  = alu_res;
                        zero_d  = (alu_res == '0);
                        valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CW'(1);
                if (mul_done) begin
                    data_d  = acc_sum;
                    zero_d  = (acc_sum == '0);
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle; honours MUL_EARLY_TERM_EN for expected MUL latency.
module tb_alu_multicycle;

    localparam int W = 32;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b011;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    logic [2:0]   op_i;
    logic [W-1:0] d1, d2;
    logic         ready_o, valid_o, zero_o;
    logic [W-1:0] data_o;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ALUCtrl_i(op_i),
        .data1_i(d1), .data2_i(d2), .ready_o(ready_o), .valid_o(valid_o),
        .data_o(data_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         zero;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   busy_from = 0;
    int   busy_until = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [W-1:0] b);
        if (op != OP_MUL) return 1;
`ifdef MUL_EARLY_TERM_EN
        for (int i = W - 1; i >= 0; i--)
            if (b[i]) return i + 2;
        return 2;
`else
        return W + 1;
`endif
    endfunction

    // Monitor: compare completions against the scoreboard and ready_o against the busy window.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready", ready_o, (cyc < busy_from) || (cyc >= busy_until));
            if (valid_o) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", valid_o, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data", data_o, e.data);
                    check("zero", zero_o, e.zero);
                    check("valid_cycle", cyc, e.due);
                end
            end else if (sb.size() != 0 && cyc >= sb[0].due) begin
                check("valid_at_due", valid_o, 1'b1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        int lat;
        exp_t e;
        n   = cyc;
        lat = latency(op, b);
        valid_i = 1'b1;
        op_i = op;
        d1 = a;
        d2 = b;
        e.data = model(op, a, b);
        e.zero = (e.data == '0);
        e.due  = n + lat;
        sb.push_back(e);
        if (op == OP_MUL) begin
            busy_from  = n + 1;
            busy_until = n + lat;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_ready();
        while (cyc < busy_until) begin
            @(posedge clk); #1;
        end
    endtask

    logic [2:0] ops [8];
    int         drain;

    initial begin
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, 3'b100, 3'b101, 3'b111};
        rst = 1'b1; valid_i = 1'b0; op_i = '0; d1 = '0; d2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready_o, 1'b1);
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", data_o, '0);
        check("rst_zero", zero_o, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(OP_SUB, 32'd5, 32'd7);
        issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
        issue(3'b101, 32'd3, 32'd4);
        issue(OP_OR, 32'h1234_0000, 32'h0000_5678);
        issue(3'b100, 32'd9, 32'd1);
        issue(3'b111, 32'hFFFF_FFFF, 32'd1);

        // MUL with operand churn and ignored requests while busy.
        issue(OP_MUL, 32'h0001_0001, 32'h0001_0001);
        d1 = 32'hDEAD_BEEF; d2 = 32'hFFFF_FFFF; op_i = OP_ADD;
        repeat (4) begin @(posedge clk); #1; end
        valid_i = 1'b1;
        @(negedge clk);
        check("ready_mid_mul", ready_o, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_ready();

        issue(OP_MUL, 32'd7, 32'd5);
        wait_ready();
        issue(OP_MUL, 32'd9, 32'd0);
        wait_ready();
        issue(OP_ADD, 32'd1, 32'd1);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_ready();
        issue(OP_MUL, 32'h0000_0003, 32'h8000_0000);
        wait_ready();

        for (int i = 0; i < 12; i++) begin
            logic [2:0] op;
            logic [W-1:0] a, b;
            op = ops[$urandom_range(0, 7)];
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            issue(op, a, b);
            wait_ready();
        end

        // Reset ten cycles into a MUL aborts it without a completion.
        issue(OP_MUL, 32'd123, 32'd456);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        sb.delete();
        busy_from = 0;
        busy_until = 0;
        #1;
        check("abort_valid", valid_o, 1'b0);
        check("abort_data", data_o, '0);
        check("abort_ready", ready_o, 1'b1);
        check("abort_zero", zero_o, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(OP_ADD, 32'd2, 32'd3);

        drain = 0;
        while (sb.size() != 0 && drain < 200) begin
            @(posedge clk); #1;
            drain++;
        end
        check("drain", sb.size(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
